// File: rtl/cmv300_pkg.sv
// Shared state encoding, default geometry and pattern codes for the CMV300 output-side emulator.
package cmv300_pkg;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_IDLE   = 3'd1,
        S_EXPOSE = 3'd2,
        S_FOT    = 3'd3,
        S_LINE   = 3'd4,
        S_HBLANK = 3'd5
    } cmv300_state_e;

    localparam int CMV300_H_ACTIVE = 648;
    localparam int CMV300_V_ACTIVE = 488;

    localparam int PAT_RAMP  = 0;
    localparam int PAT_CONST = 1;

    localparam logic [9:0] PAT_CONST_VALUE = 10'h2AA;

endpackage

// File: rtl/cmv300_pattern_gen.sv
// Combinational test-pattern pixel function; the top module registers its result.
module cmv300_pattern_gen
    import cmv300_pkg::*;
#(
    parameter int PATTERN = PAT_RAMP
) (
    input  logic [9:0] i_col,
    input  logic [8:0] i_row,
    input  logic [9:0] i_frame,
    output logic [9:0] o_pix
);

    // Pixel value per pattern; the ramp wraps from 1023 to 0 by truncation.
    always_comb begin
        o_pix = 10'd0;
        case (PATTERN)
            PAT_RAMP:  o_pix = i_col + {1'b0, i_row} + i_frame;
            PAT_CONST: o_pix = PAT_CONST_VALUE;
            default:   o_pix = 10'd0;
        endcase
    end

endmodule

// File: rtl/cmv300_sensor_emu_chk.sv
// Simulation-time checks for the emulator: legal geometry and line activity only inside a frame.
module cmv300_sensor_emu_chk #(
    parameter int H_ACTIVE        = 648,
    parameter int V_ACTIVE        = 488,
    parameter int H_BLANK         = 12,
    parameter int EXPOSURE_CYCLES = 64,
    parameter int FOT_CYCLES      = 32
) (
    input logic i_clk,
    input logic i_lval,
    input logic i_busy
);

    localparam bit PARAMS_OK = (H_ACTIVE >= 1) && (H_ACTIVE <= 1023) &&
                               (V_ACTIVE >= 1) && (V_ACTIVE <= 511) &&
                               (H_BLANK >= 1) && (H_BLANK <= 65536) &&
                               (EXPOSURE_CYCLES >= 1) && (EXPOSURE_CYCLES <= 65536) &&
                               (FOT_CYCLES >= 1) && (FOT_CYCLES <= 65536);

    // Geometry must fit the counter widths, and lval may only be high while a frame is in flight.
    always @(posedge i_clk) begin
        assert (PARAMS_OK) else $error("cmv300_sensor_emu: parameter out of range");
        assert (!(i_lval && !i_busy)) else $error("cmv300_sensor_emu: lval high while not busy");
    end

endmodule

// File: rtl/cmv300_sensor_emu.sv
// CMV300 output-side emulator: frame/line timing generator driving a registered pixel bus.
module cmv300_sensor_emu
    import cmv300_pkg::*;
#(
    parameter int H_ACTIVE        = CMV300_H_ACTIVE,
    parameter int V_ACTIVE        = CMV300_V_ACTIVE,
    parameter int H_BLANK         = 12,
    parameter int EXPOSURE_CYCLES = 64,
    parameter int FOT_CYCLES      = 32,
    parameter int PATTERN         = PAT_RAMP
) (
    input  logic        i_clk,
    input  logic        line_counter_rst,
    input  logic        i_sys_res_n,
    input  logic        i_frame_req,
    output logic        o_clk_out,
    output logic [9:0]  o_data,
    output logic        o_lval,
    output logic        o_dval,
    output logic        o_busy,
    output logic [15:0] o_frame_cnt,
    output logic        o_overrun
);

    localparam logic [15:0] EXP_LAST = 16'(EXPOSURE_CYCLES - 1);
    localparam logic [15:0] FOT_LAST = 16'(FOT_CYCLES - 1);
    localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [8:0]  V_LAST   = 9'(V_ACTIVE - 1);

    cmv300_state_e r_state;
    cmv300_state_e w_state_nxt;
    logic          r_req_q;
    logic [15:0]   r_cnt;
    logic [9:0]    r_col;
    logic [8:0]    r_row;
    logic [9:0]    r_data;
    logic          r_lval;
    logic          r_busy;
    logic [15:0]   r_frame_cnt;
    logic          r_overrun;

    logic          w_rise;
    logic          w_ovr_set;
    logic [15:0]   w_cnt_nxt;
    logic [9:0]    w_col_nxt;
    logic [8:0]    w_row_nxt;
    logic [9:0]    w_data_nxt;
    logic          w_lval_nxt;
    logic          w_busy_nxt;
    logic          w_frame_done;
    logic [9:0]    w_pix;

    assign w_rise    = i_frame_req & ~r_req_q;
    // A rise on the edge that returns to IDLE still sees r_busy=1, so it is an overrun too.
    assign w_ovr_set = i_sys_res_n & w_rise & r_busy;

    cmv300_pattern_gen #(
        .PATTERN (PATTERN)
    ) u_pattern (
        .i_col   (r_col),
        .i_row   (r_row),
        .i_frame (r_frame_cnt[9:0]),
        .o_pix   (w_pix)
    );

    cmv300_sensor_emu_chk #(
        .H_ACTIVE        (H_ACTIVE),
        .V_ACTIVE        (V_ACTIVE),
        .H_BLANK         (H_BLANK),
        .EXPOSURE_CYCLES (EXPOSURE_CYCLES),
        .FOT_CYCLES      (FOT_CYCLES)
    ) u_chk (
        .i_clk  (i_clk),
        .i_lval (r_lval),
        .i_busy (r_busy)
    );

    // Next-state, counter and output decode; outputs reflect the current state one edge later.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_col_nxt    = r_col;
        w_row_nxt    = r_row;
        w_busy_nxt   = r_busy;
        w_lval_nxt   = 1'b0;
        w_data_nxt   = 10'd0;
        w_frame_done = 1'b0;
        if (!i_sys_res_n) begin
            w_state_nxt = S_RESET;
            w_cnt_nxt   = 16'd0;
            w_col_nxt   = 10'd0;
            w_row_nxt   = 9'd0;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_RESET: w_state_nxt = S_IDLE;
                S_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = S_EXPOSE;
                        w_cnt_nxt   = 16'd0;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_EXPOSE: begin
                    if (r_cnt == EXP_LAST) begin
                        w_state_nxt = S_FOT;
                        w_cnt_nxt   = 16'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
                S_FOT: begin
                    if (r_cnt == FOT_LAST) begin
                        w_state_nxt = S_LINE;
                        w_cnt_nxt   = 16'd0;
                        w_col_nxt   = 10'd0;
                        w_row_nxt   = 9'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
                S_LINE: begin
                    w_lval_nxt = 1'b1;
                    w_data_nxt = w_pix;
                    if (r_col == H_LAST) begin
                        w_state_nxt = S_HBLANK;
                        w_cnt_nxt   = 16'd0;
                        w_col_nxt   = 10'd0;
                    end else begin
                        w_col_nxt = r_col + 10'd1;
                    end
                end
                S_HBLANK: begin
                    if (r_cnt == HB_LAST) begin
                        w_cnt_nxt = 16'd0;
                        if (r_row == V_LAST) begin
                            w_state_nxt  = S_IDLE;
                            w_row_nxt    = 9'd0;
                            w_busy_nxt   = 1'b0;
                            w_frame_done = 1'b1;
                        end else begin
                            w_state_nxt = S_LINE;
                            w_row_nxt   = r_row + 9'd1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_RESET;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge line_counter_rst) begin
        if (line_counter_rst) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, edge detector, frame statistics and registered pixel outputs.
    always_ff @(posedge i_clk or posedge line_counter_rst) begin
        if (line_counter_rst) begin
            r_req_q     <= 1'b0;
            r_cnt       <= 16'd0;
            r_col       <= 10'd0;
            r_row       <= 9'd0;
            r_data      <= 10'd0;
            r_lval      <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= 16'd0;
            r_overrun   <= 1'b0;
        end else begin
            r_req_q     <= i_frame_req;
            r_cnt       <= w_cnt_nxt;
            r_col       <= w_col_nxt;
            r_row       <= w_row_nxt;
            r_data      <= w_data_nxt;
            r_lval      <= w_lval_nxt;
            r_busy      <= w_busy_nxt;
            r_frame_cnt <= r_frame_cnt + {15'd0, w_frame_done};
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    assign o_clk_out   = i_clk;
    assign o_data      = r_data;
    assign o_lval      = r_lval;
    assign o_dval      = r_lval;
    assign o_busy      = r_busy;
    assign o_frame_cnt = r_frame_cnt;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_cmv300_sensor_emu.sv
// Directed bench: small-geometry frame table, overrun/abort/reset sequences, and a wide-line receiver count.
module tb_cmv300_sensor_emu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sys = 1'b1;
    logic req = 1'b0;
    logic b_sys = 1'b1;
    logic b_req = 1'b0;

    logic        s_clk_out, s_lval, s_dval, s_busy, s_ovr;
    logic [9:0]  s_data;
    logic [15:0] s_fcnt;
    logic        c_clk_out, c_lval, c_dval, c_busy, c_ovr;
    logic [9:0]  c_data;
    logic [15:0] c_fcnt;
    logic        b_clk_out, b_lval, b_dval, b_busy, b_ovr;
    logic [9:0]  b_data;
    logic [15:0] b_fcnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cmv300_sensor_emu #(.H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2), .EXPOSURE_CYCLES(5),
                        .FOT_CYCLES(3), .PATTERN(0)) u_small (
        .i_clk(clk), .line_counter_rst(rst), .i_sys_res_n(sys), .i_frame_req(req),
        .o_clk_out(s_clk_out), .o_data(s_data), .o_lval(s_lval), .o_dval(s_dval),
        .o_busy(s_busy), .o_frame_cnt(s_fcnt), .o_overrun(s_ovr));

    cmv300_sensor_emu #(.H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2), .EXPOSURE_CYCLES(5),
                        .FOT_CYCLES(3), .PATTERN(1)) u_const (
        .i_clk(clk), .line_counter_rst(rst), .i_sys_res_n(sys), .i_frame_req(req),
        .o_clk_out(c_clk_out), .o_data(c_data), .o_lval(c_lval), .o_dval(c_dval),
        .o_busy(c_busy), .o_frame_cnt(c_fcnt), .o_overrun(c_ovr));

    cmv300_sensor_emu #(.H_ACTIVE(1023), .V_ACTIVE(20), .H_BLANK(12), .EXPOSURE_CYCLES(64),
                        .FOT_CYCLES(32), .PATTERN(0)) u_big (
        .i_clk(clk), .line_counter_rst(rst), .i_sys_res_n(b_sys), .i_frame_req(b_req),
        .o_clk_out(b_clk_out), .o_data(b_data), .o_lval(b_lval), .o_dval(b_dval),
        .o_busy(b_busy), .o_frame_cnt(b_fcnt), .o_overrun(b_ovr));

    typedef struct {
        logic        req;
        logic        lval;
        logic [9:0]  data;
        logic        busy;
        logic [15:0] fcnt;
    } vec_t;

    vec_t tbl [1:37];

    // Receiver-style monitor for the wide-line instance, sampling on the negedge.
    logic mon_en = 1'b0;
    logic mon_prev = 1'b0;
    int   mon_col = 0;
    int   mon_lines = 0;
    int   mon_pixels = 0;
    int   mon_px_err = 0;
    int   mon_len_err = 0;
    int   mon_dv_err = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (b_dval != b_lval) mon_dv_err <= mon_dv_err + 1;
            if (b_lval) begin
                if (b_data != 10'(mon_col + mon_lines)) mon_px_err <= mon_px_err + 1;
                mon_col    <= mon_col + 1;
                mon_pixels <= mon_pixels + 1;
            end
            if (mon_prev && !b_lval) begin
                mon_lines <= mon_lines + 1;
                if (mon_col != 1023) mon_len_err <= mon_len_err + 1;
                mon_col <= 0;
            end
            mon_prev <= b_lval;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int exp_px [12] = '{0, 1, 2, 3, 1, 2, 3, 4, 2, 3, 4, 5};
        int pos;
        logic timeout;

        // Frame 0 expectations, indexed by posedge number after reset release.
        for (int e = 1; e <= 37; e++) begin
            tbl[e].req  = (e >= 10 && e <= 14);
            tbl[e].lval = 1'b0;
            tbl[e].data = 10'd0;
            tbl[e].busy = (e >= 10 && e <= 35);
            tbl[e].fcnt = (e >= 36) ? 16'd1 : 16'd0;
        end
        for (int i = 0; i < 12; i++) begin
            pos = 19 + 6 * (i / 4) + (i % 4);
            tbl[pos].lval = 1'b1;
            tbl[pos].data = 10'(exp_px[i]);
        end

        #2;
        chk("rst_lval", s_lval, 0);
        chk("rst_data", s_data, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_fcnt", s_fcnt, 0);
        chk("rst_ovr", s_ovr, 0);
        chk("clk_out_low", s_clk_out, 0);
        #4;
        chk("clk_out_high", s_clk_out, 1);
        @(negedge clk);
        rst = 1'b0;

        for (int e = 1; e <= 37; e++) begin
            req = tbl[e].req;
            tick();
            chk($sformatf("e%0d_lval", e), s_lval, tbl[e].lval);
            chk($sformatf("e%0d_dval", e), s_dval, tbl[e].lval);
            chk($sformatf("e%0d_data", e), s_data, tbl[e].data);
            chk($sformatf("e%0d_busy", e), s_busy, tbl[e].busy);
            chk($sformatf("e%0d_fcnt", e), s_fcnt, tbl[e].fcnt);
            chk($sformatf("e%0d_ovr", e), s_ovr, 0);
            chk($sformatf("e%0d_const", e), c_data, tbl[e].lval ? 682 : 0);
        end

        // Frame 1: ramp offset by frame count; a second request during the line is an overrun.
        req = 1'b1;
        tick();
        chk("f1_busy", s_busy, 1);
        ticks(8);
        chk("f1_pre_lval", s_lval, 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("f1_c%0d_lval", c), s_lval, 1);
            chk($sformatf("f1_c%0d_data", c), s_data, c + 1);
            if (c == 0) req = 1'b0;
            if (c == 1) req = 1'b1;
            if (c == 2) req = 1'b0;
        end
        chk("f1_ovr_set", s_ovr, 1);
        ticks(13);
        chk("f1_busy_last", s_busy, 1);
        tick();
        chk("f1_busy_fall", s_busy, 0);
        chk("f1_fcnt", s_fcnt, 2);
        ticks(20);
        chk("f1_no_extra_busy", s_busy, 0);
        chk("f1_no_extra_fcnt", s_fcnt, 2);
        chk("f1_ovr_sticky", s_ovr, 1);

        // Frame 2 aborted by a one-clock sensor reset during row 1.
        req = 1'b1;
        tick();
        ticks(15);
        chk("ab_lval_row1", s_lval, 1);
        chk("ab_data_row1", s_data, 3);
        sys = 1'b0;
        tick();
        chk("ab_lval", s_lval, 0);
        chk("ab_data", s_data, 0);
        chk("ab_busy", s_busy, 0);
        sys = 1'b1;
        req = 1'b0;
        ticks(20);
        chk("ab_idle_lval", s_lval, 0);
        chk("ab_idle_busy", s_busy, 0);
        chk("ab_fcnt", s_fcnt, 2);
        chk("ab_ovr", s_ovr, 1);
        req = 1'b1;
        tick();
        req = 1'b0;
        ticks(8);
        chk("rf_pre_lval", s_lval, 0);
        tick();
        chk("rf_first_lval", s_lval, 1);
        chk("rf_first_data", s_data, 2);
        ticks(17);
        chk("rf_busy", s_busy, 0);
        chk("rf_fcnt", s_fcnt, 3);

        // Asynchronous reset in the middle of a line.
        req = 1'b1;
        tick();
        ticks(10);
        chk("ar_pre_lval", s_lval, 1);
        chk("ar_pre_data", s_data, 4);
        rst = 1'b1;
        #1;
        chk("ar_lval", s_lval, 0);
        chk("ar_data", s_data, 0);
        chk("ar_busy", s_busy, 0);
        chk("ar_fcnt", s_fcnt, 0);
        chk("ar_ovr", s_ovr, 0);
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;

        // Wide-line frame counted by the negedge receiver monitor.
        ticks(2);
        mon_en = 1'b1;
        b_req = 1'b1;
        timeout = 1'b1;
        for (int i = 0; i < 30000; i++) begin
            tick();
            if (i > 0 && !b_busy) begin
                timeout = 1'b0;
                break;
            end
        end
        chk("big_timeout", timeout, 0);
        ticks(2);
        chk("big_lines", mon_lines, 20);
        chk("big_pixels", mon_pixels, 20460);
        chk("big_line_len_err", mon_len_err, 0);
        chk("big_pixel_err", mon_px_err, 0);
        chk("big_dval_err", mon_dv_err, 0);
        chk("big_fcnt", b_fcnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
